// File: rtl/vga_sync_if.sv
// Timing bundle produced by vga_sync: pixel/line counters, syncs and strobes.
// The master drives everything; slaves (pixel generators) only observe.
interface vga_sync_if;
    logic [9:0] x;
    logic [9:0] y;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic       frame_start;

    modport master (output x, y, hsync, vsync, video_on, p_tick, frame_start);
    modport slave  (input  x, y, hsync, vsync, video_on, p_tick, frame_start);
endinterface

// File: rtl/vga_sync.sv
// VGA timing generator: clock divider, free-running pixel/line counters and
// registered active-low syncs, visible-area flag and frame-start pulse.
module vga_sync #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    vga_sync_if.master vga
);
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             tick;
    logic             frame_wrap;
    logic             hsync_q, vsync_q, video_on_q, frame_start_q;

    always_comb begin
        tick       = (div_q == DIV_LAST);
        frame_wrap = tick && (x_q == X_LAST) && (y_q == Y_LAST);
        div_d      = tick ? '0 : div_q + 1'b1;
        x_d        = x_q;
        y_d        = y_q;
        if (tick) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Syncs and video_on are decoded from next-state counters so they
    // switch on the same edge as x/y.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= !((x_d >= HS_START) && (x_d < HS_END));
            vsync_q       <= !((y_d >= VS_START) && (y_d < VS_END));
            video_on_q    <= (x_d < H_VIS) && (y_d < V_VIS);
            frame_start_q <= frame_wrap;
        end
    end

    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_on_q;
    assign vga.p_tick      = tick;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: default-timing and shrunken-timing instances checked
// cycle by cycle against a closed-form model of elapsed time since reset.
module tb_vga_sync;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       pt;
        logic       fs;
    } exp_t;

    logic clk;
    logic rst_n;

    vga_sync_if if_a ();
    vga_sync_if if_b ();

    vga_sync u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (if_a)
    );

    vga_sync #(
        .H_DISPLAY (8),
        .H_FRONT   (2),
        .H_SYNC    (2),
        .H_BACK    (2),
        .V_DISPLAY (4),
        .V_FRONT   (1),
        .V_SYNC    (1),
        .V_BACK    (1),
        .CLK_DIV   (2)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned t_a      = 0;
    int unsigned t_b      = 0;
    bit          started  = 0;
    bit          win_a    = 0;
    bit          win_b    = 0;
    int unsigned hs_low_a = 0, pt_a = 0, vo_a = 0;
    int unsigned hs_low_b = 0, vs_low_b = 0, vo_b = 0, fs_b = 0, pt_b = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Outputs as a function of cycles elapsed since the last reset edge.
    function automatic exp_t model(input int unsigned t,
                                   input int unsigned hd, input int unsigned hf,
                                   input int unsigned hs, input int unsigned hb,
                                   input int unsigned vd, input int unsigned vf,
                                   input int unsigned vs, input int unsigned vb,
                                   input int unsigned d);
        exp_t m;
        int unsigned ht = hd + hf + hs + hb;
        int unsigned vt = vd + vf + vs + vb;
        int unsigned pix = t / d;
        int unsigned xx = pix % ht;
        int unsigned yy = (pix / ht) % vt;
        m.x  = 10'(xx);
        m.y  = 10'(yy);
        m.pt = ((t % d) == d - 1);
        m.hs = !((xx >= hd + hf) && (xx < hd + hf + hs));
        m.vs = !((yy >= vd + vf) && (yy < vd + vf + vs));
        m.vo = (t != 0) && (xx < hd) && (yy < vd);
        m.fs = (t != 0) && ((t % (d * ht * vt)) == 0);
        return m;
    endfunction

    // One clock: model the edge using the rst_n the DUT samples, then drive
    // the reset level for the following edge.
    task automatic step(input logic rst_next);
        @(posedge clk);
        if (!rst_n) begin
            t_a = 0;
            t_b = 0;
        end else begin
            t_a++;
            t_b++;
        end
        q_a.push_back(model(t_a, 640, 16, 96, 48, 480, 10, 2, 33, 4));
        q_b.push_back(model(t_b, 8, 2, 2, 2, 4, 1, 1, 1, 2));
        started = 1;
        #1 rst_n = rst_next;
    endtask

    initial begin
        exp_t ea;
        exp_t eb;
        forever begin
            @(negedge clk);
            if (started) begin
                if (q_a.size() == 0) check("sb_a_empty", 0, 1);
                else begin
                    ea = q_a.pop_front();
                    check("a_x", if_a.x, ea.x);
                    check("a_y", if_a.y, ea.y);
                    check("a_hsync", if_a.hsync, ea.hs);
                    check("a_vsync", if_a.vsync, ea.vs);
                    check("a_video_on", if_a.video_on, ea.vo);
                    check("a_p_tick", if_a.p_tick, ea.pt);
                    check("a_frame_start", if_a.frame_start, ea.fs);
                end
                if (q_b.size() == 0) check("sb_b_empty", 0, 1);
                else begin
                    eb = q_b.pop_front();
                    check("b_x", if_b.x, eb.x);
                    check("b_y", if_b.y, eb.y);
                    check("b_hsync", if_b.hsync, eb.hs);
                    check("b_vsync", if_b.vsync, eb.vs);
                    check("b_video_on", if_b.video_on, eb.vo);
                    check("b_p_tick", if_b.p_tick, eb.pt);
                    check("b_frame_start", if_b.frame_start, eb.fs);
                end
                if (win_a) begin
                    hs_low_a += int'(!if_a.hsync);
                    pt_a     += int'(if_a.p_tick);
                    vo_a     += int'(if_a.video_on);
                end
                if (win_b) begin
                    hs_low_b += int'(!if_b.hsync);
                    vs_low_b += int'(!if_b.vsync);
                    vo_b     += int'(if_b.video_on);
                    fs_b     += int'(if_b.frame_start);
                    pt_b     += int'(if_b.p_tick);
                end
            end
        end
    end

    initial begin
        int unsigned guard;
        rst_n = 1'b0;
        repeat (3) step(1'b0);
        step(1'b1);
        repeat (400) step(1'b1);

        // One full small frame and one full default line, in steady state.
        win_b = 1;
        repeat (196) step(1'b1);
        win_b = 0;
        win_a = 1;
        repeat (3200) step(1'b1);
        win_a = 0;
        check("a_line_hsync_low", hs_low_a, 384);
        check("a_line_p_ticks", pt_a, 800);
        check("a_line_video_on", vo_a, 2560);
        check("b_frame_hsync_low", hs_low_b, 28);
        check("b_frame_vsync_low", vs_low_b, 28);
        check("b_frame_video_on", vo_b, 64);
        check("b_frame_start_cnt", fs_b, 1);
        check("b_frame_p_ticks", pt_b, 98);

        // Reset the small instance while both its syncs are low (x=11, y=5).
        guard = 0;
        while ((t_b % 196) != 161 && guard < 400) begin
            step(1'b1);
            guard++;
        end
        check("b_sync_align", t_b % 196, 161);
        step(1'b0);
        step(1'b1);
        repeat (600) step(1'b1);

        // Reset the default instance mid-hsync at x=700.
        guard = 0;
        while (t_a != 2801 && guard < 4000) begin
            step(1'b1);
            guard++;
        end
        check("a_hsync_align", t_a, 2801);
        step(1'b0);
        step(1'b1);
        repeat (3300) step(1'b1);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
- REQ-001 Parameter H_DISPLAY, 640, visible pixels per line.
- REQ-002 Parameter H_FRONT, 16, horizontal front porch (pixels).
- REQ-003 Parameter H_SYNC, 96, horizontal sync width (pixels).
- REQ-004 Parameter H_BACK, 48, horizontal back porch (pixels).
- REQ-005 Parameter V_DISPLAY, 480, visible lines per frame.
- REQ-006 Parameter V_FRONT, 10, vertical front porch (lines).
- REQ-007 Parameter V_SYNC, 2, vertical sync width (lines).
- REQ-008 Parameter V_BACK, 33, vertical back porch (lines).
- REQ-009 Parameter CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz).
- REQ-010 clk  input  1  system clock; the single clock; all state updates on its rising edge.
- REQ-011 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- REQ-012 x  output  10  current horizontal pixel count, 0..H_TOTAL-1; drives glyph/paddle/ball pixel tests.
- REQ-013 y  output  10  current vertical line count, 0..V_TOTAL-1.
- REQ-014 hsync  output  1  horizontal sync, active low.
- REQ-015 vsync  output  1  vertical sync, active low.
- REQ-016 video_on  output  1  high when (x,y) lies in the visible area.
- REQ-017 p_tick  output  1  one-clk pixel-enable strobe.
- REQ-018 frame_start  output  1  one-clk pulse at start of each frame.

Function
- REQ-019 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- REQ-020 Divider counter counts 0..CLK_DIV-1 every clk, wrapping to 0; p_tick is high exactly in cycles where divider = CLK_DIV-1.
- REQ-021 x increments by 1 on the rising edge ending a p_tick-high cycle; x holds for CLK_DIV clks per value.
- REQ-022 When x = H_TOTAL-1 and p_tick high: x wraps to 0 and y increments on the same edge.
- REQ-023 When x = H_TOTAL-1, y = V_TOTAL-1 and p_tick high: x and y both wrap to 0 on the same edge.
- REQ-024 x, y never exceed H_TOTAL-1, V_TOTAL-1; no out-of-range value ever visible.
- REQ-025 hsync low iff H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC (656..751); else high.
- REQ-026 vsync low iff V_DISPLAY+V_FRONT <= y < V_DISPLAY+V_FRONT+V_SYNC (490..491); else high.
- REQ-027 video_on = (x < H_DISPLAY) and (y < V_DISPLAY).
- REQ-028 hsync, vsync, video_on registered, computed from next-state counters, so they change on the same edge as x/y (zero-cycle skew to x/y).
- REQ-029 frame_start registered; high for exactly one clk: the first clk in which (x,y) = (0,0) after a wrap (REQ-023); not asserted on exit from reset.
- REQ-030 Counters are free-running; no enable or stall input.

Reset
- REQ-031 While rst_n low at a rising edge: divider=0, x=0, y=0, hsync=1, vsync=1, video_on=0, p_tick=0, frame_start=0.
- REQ-032 Cycle 0 = first clk with rst_n high: p_tick high in cycles 3, 7, 11, ...; x becomes 1 at end of cycle 3; video_on becomes 1 at end of cycle 0.
- REQ-033 Reset asserted mid-frame, mid-sync or mid-p_tick takes effect on the next rising edge regardless of state; no partial pulse completes.

Verification
- REQ-034 Release reset, run 3200 clks -> p_tick period 4 clks; x runs 0..799 and wraps to 0 at clk 3200 with y=1.
- REQ-035 Line timing -> hsync low for exactly 384 clks starting when x=656, high at x=752; period 3200 clks.
- REQ-036 Full frame, 1,680,000 clks -> vsync low for exactly 6400 clks starting at y=490,x=0; frame_start single 1-clk pulse at clk 1,680,000 with (x,y)=(0,0); none at reset release.
- REQ-037 video_on check over one frame -> high for exactly 640*480*4 = 1,228,800 clks; low whenever x>=640 or y>=480.
- REQ-038 Assert rst_n low for 1 clk at x=700,y=491 (both syncs low) -> next edge x=0,y=0,hsync=1,vsync=1,video_on=0,frame_start=0; timing restarts per REQ-032.
- REQ-039 Override parameters (H 8/2/2/2, V 4/1/1/1, CLK_DIV 2) -> wrap at x=13, y=6; sync windows at x=10..11, y=5 scale accordingly.
